// File: rtl/keypad_lock_pkg.sv
// Shared types and key constants for the keypad lock controller.
package keypad_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_e;

  localparam logic [3:0] KEY_SET    = 4'hE;
  localparam logic [3:0] KEY_CANCEL = 4'hD;
  localparam logic [3:0] KEY_NONE   = 4'hF;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'h9;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_timer.sv
// Loadable down-counter shared by the unlock hold and the lockout period.
module lock_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // Flag the last counted cycle so the owner leaves exactly load_val cycles after loading.
  assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock controller: full-code compare, timed unlock, fail lockout, programming mode.
// Optional CODE_CONFIRM_EN: new code must be entered twice in PROG before it is committed.
//
// state      | meaning
// IDLE       | waiting for first digit, buffer empty
// ENTRY      | collecting code digits
// OPEN       | lock_open high until timer expires, CANCEL or SET
// PROG       | collecting a new code
// LOCKOUT    | all keys ignored until timer expires
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int CODE_LEN       = 4,
  parameter int UNLOCK_CYCLES  = 10_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           key_valid_i,
  input  logic [3:0]                     key_code_i,
  output logic                           lock_open_o,
  output logic                           lockout_o,
  output logic                           prog_mode_o,
  output logic                           err_pulse_o,
  output logic                           prog_done_o,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count_o
);

  localparam int FW      = $clog2(MAX_FAILS + 1);
  localparam int CW      = $clog2(CODE_LEN + 1);
  localparam int BW      = CODE_LEN * 4;
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);

  lock_state_e   state_q;
  logic [BW-1:0] code_q;
  logic [BW-1:0] buf_q;
  logic [CW-1:0] cnt_q;
  logic [FW-1:0] fail_q;
  logic          lock_open_q;
  logic          lockout_q;
  logic          prog_mode_q;
  logic          err_pulse_q;
  logic          prog_done_q;
`ifdef CODE_CONFIRM_EN
  logic [BW-1:0] first_q;
  logic          pass_q;
`endif

  logic [BW-1:0] entry_buf;
  logic          key_digit;
  logic          last_digit;
  logic          match;
  logic [FW-1:0] fail_inc;
  logic          go_lockout;
  logic          eval;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expired;

  always_comb begin
    entry_buf = buf_q;
    entry_buf[int'(cnt_q)*4 +: 4] = key_code_i;
    key_digit  = key_valid_i && is_digit(key_code_i);
    last_digit = (cnt_q == CW'(CODE_LEN - 1));
    match      = (entry_buf == code_q);
    fail_inc   = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);
    eval       = key_digit && last_digit && (state_q == ST_IDLE || state_q == ST_ENTRY);
    go_lockout = eval && !match && (fail_inc == FW'(MAX_FAILS));
    tmr_load   = eval && (match || go_lockout);
    tmr_val    = match ? TW'(UNLOCK_CYCLES) : TW'(LOCKOUT_CYCLES);
  end

  lock_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      fail_q      <= '0;
      lock_open_q <= 1'b0;
      lockout_q   <= 1'b0;
      prog_mode_q <= 1'b0;
      err_pulse_q <= 1'b0;
      prog_done_q <= 1'b0;
`ifdef CODE_CONFIRM_EN
      first_q     <= '0;
      pass_q      <= 1'b0;
`endif
    end else begin
      err_pulse_q <= 1'b0;
      prog_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if (key_digit) begin
            if (last_digit) begin
              buf_q <= '0;
              cnt_q <= '0;
              if (match) begin
                state_q     <= ST_OPEN;
                lock_open_q <= 1'b1;
                fail_q      <= '0;
              end else begin
                err_pulse_q <= 1'b1;
                fail_q      <= fail_inc;
                if (go_lockout) begin
                  state_q   <= ST_LOCKOUT;
                  lockout_q <= 1'b1;
                end else begin
                  state_q   <= ST_IDLE;
                end
              end
            end else begin
              buf_q   <= entry_buf;
              cnt_q   <= cnt_q + CW'(1);
              state_q <= ST_ENTRY;
            end
          end else if (key_valid_i && key_code_i == KEY_CANCEL && state_q == ST_ENTRY) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ST_OPEN: begin
          if (tmr_expired) begin
            state_q     <= ST_IDLE;
            lock_open_q <= 1'b0;
          end else if (key_valid_i && key_code_i == KEY_CANCEL) begin
            state_q     <= ST_IDLE;
            lock_open_q <= 1'b0;
          end else if (key_valid_i && key_code_i == KEY_SET) begin
            state_q     <= ST_PROG;
            lock_open_q <= 1'b0;
            prog_mode_q <= 1'b1;
            buf_q       <= '0;
            cnt_q       <= '0;
`ifdef CODE_CONFIRM_EN
            pass_q      <= 1'b0;
`endif
          end
        end
        ST_PROG: begin
          if (key_digit) begin
            if (last_digit) begin
              buf_q <= '0;
              cnt_q <= '0;
`ifdef CODE_CONFIRM_EN
              if (!pass_q) begin
                first_q <= entry_buf;
                pass_q  <= 1'b1;
              end else begin
                if (entry_buf == first_q) begin
                  code_q      <= entry_buf;
                  prog_done_q <= 1'b1;
                end else begin
                  err_pulse_q <= 1'b1;
                end
                pass_q      <= 1'b0;
                prog_mode_q <= 1'b0;
                state_q     <= ST_IDLE;
              end
`else
              code_q      <= entry_buf;
              prog_done_q <= 1'b1;
              prog_mode_q <= 1'b0;
              state_q     <= ST_IDLE;
`endif
            end else begin
              buf_q <= entry_buf;
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (key_valid_i && key_code_i == KEY_CANCEL) begin
            state_q     <= ST_IDLE;
            prog_mode_q <= 1'b0;
            buf_q       <= '0;
            cnt_q       <= '0;
`ifdef CODE_CONFIRM_EN
            pass_q      <= 1'b0;
`endif
          end else if (key_valid_i && key_code_i == KEY_SET) begin
            buf_q <= '0;
            cnt_q <= '0;
`ifdef CODE_CONFIRM_EN
            pass_q <= 1'b0;
`endif
          end
        end
        ST_LOCKOUT: begin
          if (tmr_expired) begin
            state_q   <= ST_IDLE;
            lockout_q <= 1'b0;
            fail_q    <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lock_open_o  = lock_open_q;
  assign lockout_o    = lockout_q;
  assign prog_mode_o  = prog_mode_q;
  assign err_pulse_o  = err_pulse_q;
  assign prog_done_o  = prog_done_q;
  assign fail_count_o = fail_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios plus random episodes against a digit-queue model.
module tb_keypad_lock_ctrl;

  localparam int CODE_LEN       = 4;
  localparam int UNLOCK_CYCLES  = 8;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int FW             = $clog2(MAX_FAILS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic          lock_open, lockout, prog_mode, err_pulse, prog_done;
  logic [FW-1:0] fail_count;

  keypad_lock_ctrl #(
    .CODE_LEN       (CODE_LEN),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid_i  (key_valid),
    .key_code_i   (key_code),
    .lock_open_o  (lock_open),
    .lockout_o    (lockout),
    .prog_mode_o  (prog_mode),
    .err_pulse_o  (err_pulse),
    .prog_done_o  (prog_done),
    .fail_count_o (fail_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  // Reference model: digits typed so far, remaining open/lockout cycles, programming flag.
  logic [3:0] m_code  [CODE_LEN];
  logic [3:0] m_first [CODE_LEN];
  logic [3:0] m_buf[$];
  int         m_open_left, m_lock_left, m_fails;
  bit         m_prog, m_pass, m_err, m_done;

  task automatic model_reset();
    for (int i = 0; i < CODE_LEN; i++) begin
      m_code[i]  = 4'h0;
      m_first[i] = 4'h0;
    end
    m_buf.delete();
    m_open_left = 0; m_lock_left = 0; m_fails = 0;
    m_prog = 0; m_pass = 0; m_err = 0; m_done = 0;
  endtask

  function automatic bit buf_equals_code();
    for (int i = 0; i < CODE_LEN; i++) if (m_buf[i] != m_code[i]) return 0;
    return 1;
  endfunction

  function automatic bit buf_equals_first();
    for (int i = 0; i < CODE_LEN; i++) if (m_buf[i] != m_first[i]) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [3:0] k);
    bit dig;
    dig = v && (k <= 4'h9);
    m_err = 0; m_done = 0;
    if (!r) begin
      model_reset();
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_open_left > 0) begin
      m_open_left--;
      if (m_open_left > 0 && v && k == 4'hD) begin
        m_open_left = 0;
      end else if (m_open_left > 0 && v && k == 4'hE) begin
        m_open_left = 0; m_prog = 1; m_pass = 0; m_buf.delete();
      end
    end else if (m_prog) begin
      if (dig) begin
        m_buf.push_back(k);
        if (m_buf.size() == CODE_LEN) begin
`ifdef CODE_CONFIRM_EN
          if (!m_pass) begin
            for (int i = 0; i < CODE_LEN; i++) m_first[i] = m_buf[i];
            m_pass = 1;
          end else begin
            if (buf_equals_first()) begin
              for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_buf[i];
              m_done = 1;
            end else m_err = 1;
            m_pass = 0; m_prog = 0;
          end
`else
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_buf[i];
          m_done = 1; m_prog = 0;
`endif
          m_buf.delete();
        end
      end else if (v && k == 4'hD) begin
        m_prog = 0; m_pass = 0; m_buf.delete();
      end else if (v && k == 4'hE) begin
        m_pass = 0; m_buf.delete();
      end
    end else begin
      if (dig) begin
        m_buf.push_back(k);
        if (m_buf.size() == CODE_LEN) begin
          if (buf_equals_code()) begin
            m_open_left = UNLOCK_CYCLES; m_fails = 0;
          end else begin
            m_err = 1;
            m_fails = (m_fails + 1 > MAX_FAILS) ? MAX_FAILS : m_fails + 1;
            if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
          end
          m_buf.delete();
        end
      end else if (v && k == 4'hD) begin
        m_buf.delete();
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [3:0] k);
    rst_n = r; key_valid = v; key_code = k;
    @(posedge clk);
    model_step(r, v, k);
    #1;
    check_val("lock_open",  int'(lock_open),  int'(m_open_left > 0));
    check_val("lockout",    int'(lockout),    int'(m_lock_left > 0));
    check_val("prog_mode",  int'(prog_mode),  int'(m_prog));
    check_val("err_pulse",  int'(err_pulse),  int'(m_err));
    check_val("prog_done",  int'(prog_done),  int'(m_done));
    check_val("fail_count", int'(fail_count), m_fails);
  endtask

  task automatic press(input logic [3:0] k);
    cycle(1, 1, k);
    cycle(1, 0, 4'h0);
  endtask

  task automatic press_code(input logic [15:0] c);
    for (int i = CODE_LEN - 1; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 4'h0);
  endtask

  initial begin
    model_reset();
    cycle(0, 0, 4'h0);
    cycle(0, 1, 4'h3);
    check_val("reset_lock_open", int'(lock_open), 0);
    check_val("reset_fail_count", int'(fail_count), 0);

    // Default code unlocks, held then relocks on its own.
    press_code(16'h0000);
    idle(12);

    // Three wrong codes reach lockout; keys during lockout are dropped.
    press_code(16'h1234);
    press_code(16'h1234);
    press_code(16'h1234);
    check_val("lockout_entered", int'(lockout), 1);
    press_code(16'h0000);
    idle(12);
    check_val("lockout_cleared", int'(lockout), 0);

    // Programming a new code.
    press_code(16'h0000);
    press(4'hE);
    press_code(16'h5678);
`ifdef CODE_CONFIRM_EN
    press_code(16'h5678);
`endif
    press_code(16'h0000);
    press_code(16'h5678);
    check_val("new_code_open", int'(lock_open), 1);
    press(4'hD);
    check_val("cancel_relock", int'(lock_open), 0);

    // Cancel mid-entry does not count as a failure.
    press(4'h5); press(4'h6); press(4'hD);
    press_code(16'h5678);
    idle(10);

    // SET arriving on the expiry cycle is dropped.
    press_code(16'h5678);
    idle(UNLOCK_CYCLES - 2);
    cycle(1, 1, 4'hE);
    check_val("expiry_drops_key", int'(prog_mode), 0);
    idle(2);

    // Reset in the middle of programming restores the zero code.
    press_code(16'h5678);
    press(4'hE);
    press(4'h9); press(4'h9);
    cycle(0, 0, 4'h0);
    check_val("reset_mid_prog", int'(prog_mode), 0);
    press_code(16'h0000);
    idle(10);

`ifdef CODE_CONFIRM_EN
    press_code(16'h0000);
    press(4'hE);
    press_code(16'h1111);
    press_code(16'h2222);
    press_code(16'h0000);
    idle(10);
`endif

    // Random episodes.
    for (int ep = 0; ep < 400; ep++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: begin
          for (int i = 0; i < CODE_LEN; i++) begin
            cycle(1, 1, m_code[i]);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
          end
        end
        2: press(4'(($urandom_range(0, 1) == 0) ? 4'hE : 4'hD));
        3: begin
          press(4'hE);
          for (int i = 0; i < CODE_LEN; i++) press(4'($urandom_range(0, 3)));
        end
        4: idle($urandom_range(0, 20));
        5: cycle(1, 1, 4'($urandom_range(10, 15)));
        6: cycle(($urandom_range(0, 30) == 0) ? 1'b0 : 1'b1, 1'b0, 4'h0);
        default: cycle(1, 1, 4'($urandom_range(0, 3)));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
Parametrised keypad lock controller: accepts keypress strobes, checks an N-digit passcode and drives a timed unlock output. Adds what the single-cycle lock lacked: parametrised code length, full-code comparison (no per-digit leak), failed-attempt counting with timed lockout, and explicit programming mode. Sits between the keypad decoder (ui_in) and the actuator output (uo_out).

Parameters:
CODE_LEN, 4, passcode digits (1..8)
UNLOCK_CYCLES, 10_000_000, cycles lock_open held after correct code
MAX_FAILS, 3, consecutive wrong codes before lockout (1..15)
LOCKOUT_CYCLES, 50_000_000, cycles keypad ignored in lockout

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0x0-0x9 digit, 0xE SET, 0xD CANCEL, others ignored
lock_open  out  1  actuator enable
lockout  out  1  high in LOCKOUT
prog_mode  out  1  high in PROG
err_pulse  out  1  one-cycle pulse on wrong code / rejected programming
prog_done  out  1  one-cycle pulse on new code committed
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures

Behaviour:
- Reset: state IDLE, stored code all 0x0, entry buffer/digit counter/timer/fail_count 0; all outputs 0.
- States: IDLE, ENTRY, OPEN, PROG, LOCKOUT. All outputs registered, valid the cycle after the causing key.
- Keys only act when key_valid=1; codes 0xA-0xC, 0xF always ignored.
- IDLE: digit -> store as digit 0, count=1, ENTRY (if CODE_LEN==1 evaluate immediately as below). SET/CANCEL ignored.
- ENTRY: digit appended, count++. On CODE_LEN-th digit compare full buffer vs stored code:
  match -> OPEN, load timer UNLOCK_CYCLES, fail_count=0;
  mismatch -> err_pulse, fail_count+1; if new value == MAX_FAILS -> LOCKOUT (timer LOCKOUT_CYCLES) else IDLE.
  CANCEL -> IDLE, buffer cleared, fail_count unchanged. SET ignored.
- OPEN: lock_open=1; timer decrements; reaching 0 -> IDLE. CANCEL -> IDLE immediately (relock). SET -> PROG, count=0. Digits ignored.
- PROG: lock_open=0, prog_mode=1. Digits fill buffer; on CODE_LEN-th digit commit to stored code, prog_done, -> IDLE. CANCEL -> IDLE, old code kept. SET restarts entry (count=0).
- LOCKOUT: lockout=1; all keys including CANCEL ignored; timer 0 -> IDLE, fail_count=0.
- Timer expiry coincident with key_valid: expiry wins, key discarded.
- fail_count saturates at MAX_FAILS; cleared only by successful unlock, lockout expiry or reset.
- Reset mid-operation (any state): immediate return to reset values, stored code reverts to zeros.

Optional Feature:
CODE_CONFIRM_EN: defined -> PROG requires new code entered twice; second pass equal -> commit + prog_done; unequal -> err_pulse, old code kept, -> IDLE. prog_mode stays high both passes. Undefined -> single-pass commit as above.

Decomposition:
- Package keypad_lock_pkg: state enum, key constants (KEY_SET=4'hE, KEY_CANCEL=4'hD, KEY_NONE=4'hF), is_digit function.
- Sub-module lock_timer: loadable down-counter (load, load_val, expired), width $clog2 of max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1; shared by OPEN and LOCKOUT.

Test Plan:
(Bench uses CODE_LEN=4, UNLOCK_CYCLES=8, MAX_FAILS=3, LOCKOUT_CYCLES=16.)
- Reset, keys 0,0,0,0 -> lock_open=1 cycle after 4th key, held 8 cycles, then 0; fail_count=0.
- Keys 1,2,3,4 three times -> err_pulse each time, fail_count 1,2,3, lockout=1; keys ignored 16 cycles; then lockout=0, fail_count=0.
- Unlock, SET, 5,6,7,8 -> prog_done pulse; 0,0,0,0 -> err_pulse; 5,6,7,8 -> lock_open=1.
- Keys 0,0, CANCEL, 0,0,0,0 -> no err_pulse, unlock on last key; CANCEL while OPEN -> lock_open=0 next cycle.
- Key strobe on timer-expiry cycle -> key dropped, state IDLE; rst_n low mid-PROG -> all outputs 0, code back to 0000.
- CODE_CONFIRM_EN: SET, 1111 then 2222 -> err_pulse, 0000 still unlocks.
